jtag_host: RTL

JTAG initiator that drives TCK/TMS/TDI toward a JTAG target (TAP) and samples TDO. It is the driving end of the same JTAG port the SoC debug module exposes as a target. Each request is one IR scan, one DR scan, or a TAP reset sequence, always starting and ending in Run-Test/Idle. The block serves as an on-board debug bridge and as the bench-side JTAG driver for SoC simulation.

---
 rtl/jtag_host_if.sv | 30 +++
 rtl/jtag_host.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/jtag_host_if.sv
// jtag_host_if: request/response handshake and JTAG pin bundle for jtag_host.
//   Request : i_req_valid, o_req_ready, i_req_ir, i_req_len[6:0], i_req_data[63:0]
//   Response: o_resp_valid, i_resp_ready, o_resp_data[63:0]
//   JTAG    : o_tck, o_tms, o_tdi (driven toward the target), i_tdo (from the target)
// Signal prefixes are from the host's point of view. The master modport is the
// host; the slave modport is whatever sits on the other side (bus user plus TAP).
interface jtag_host_if;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_ir;
    logic [6:0]  i_req_len;
    logic [63:0] i_req_data;
    logic        o_resp_valid;
    logic        i_resp_ready;
    logic [63:0] o_resp_data;
    logic        o_tck;
    logic        o_tms;
    logic        o_tdi;
    logic        i_tdo;

    modport master (
        input  i_req_valid, i_req_ir, i_req_len, i_req_data, i_resp_ready, i_tdo,
        output o_req_ready, o_resp_valid, o_resp_data, o_tck, o_tms, o_tdi
    );

    modport slave (
        output i_req_valid, i_req_ir, i_req_len, i_req_data, i_resp_ready, i_tdo,
        input  o_req_ready, o_resp_valid, o_resp_data, o_tck, o_tms, o_tdi
    );
endinterface

// File: rtl/jtag_host.sv
// jtag_host: JTAG initiator. Each accepted request runs one IR scan, one DR scan
// or a TAP reset sequence (len=0), starting and ending in Run-Test/Idle, and
// returns the captured TDO bits on the response channel.
//   i_clk   : system clock
//   i_nrst  : asynchronous active-low reset
//   bus     : jtag_host_if.master (request, response and JTAG pins)
// CLK_DIV is the number of i_clk cycles per TCK half-period (>= 1).
module jtag_host #(
    parameter int CLK_DIV = 2
) (
    input  logic        i_clk,
    input  logic        i_nrst,
    jtag_host_if.master bus
);

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, PRE, SHIFT, POST, RESP} state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q;
    logic             tck_q;
    logic             tms_q, tms_d;
    logic             tdi_q, tdi_d;
    logic [6:0]       bit_q, bit_d;
    logic [6:0]       bit_nxt;
    logic             ir_q;
    logic [6:0]       len_q;
    logic [63:0]      data_q;
    logic [63:0]      cap_q;
    logic [6:0]       len_clip;
    logic [6:0]       pre_len;
    logic [6:0]       phase_len;
    logic             last_bit;
    logic             bit_done;
    logic             sample;
    logic             accept;

    // Header TMS bit for index idx of the PRE phase.
    //   reset: 1,1,1,1,1,0   IR: 1,1,0,0   DR: 1,0,0
    function automatic logic pre_tms(input logic is_rst, input logic is_ir, input logic [6:0] idx);
        if (is_rst)
            return idx < 7'd5;
        else if (is_ir)
            return idx < 7'd2;
        else
            return idx == 7'd0;
    endfunction

    assign len_clip  = (bus.i_req_len > 7'd64) ? 7'd64 : bus.i_req_len;
    assign pre_len   = (len_q == 7'd0) ? 7'd6 : (ir_q ? 7'd4 : 7'd3);
    assign phase_len = (state_q == PRE) ? pre_len : (state_q == SHIFT) ? len_q : 7'd2;
    assign last_bit  = (bit_q == phase_len - 7'd1);
    assign bit_nxt   = bit_q + 7'd1;

    // A bit ends on the last cycle of its high half; TDO is taken on the first
    // cycle TCK is high, i.e. the cycle in which the target sees the rising edge.
    assign bit_done  = tck_q && (div_q == DIV_LAST);
    assign sample    = (state_q == SHIFT) && tck_q && (div_q == '0);

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        tms_d   = tms_q;
        tdi_d   = tdi_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.i_req_valid) begin
                    accept  = 1'b1;
                    state_d = PRE;
                    bit_d   = 7'd0;
                    tms_d   = 1'b1;
                    tdi_d   = 1'b0;
                end
            end
            PRE: begin
                if (bit_done) begin
                    if (!last_bit) begin
                        bit_d = bit_nxt;
                        tms_d = pre_tms(len_q == 7'd0, ir_q, bit_nxt);
                    end else if (len_q == 7'd0) begin
                        state_d = RESP;
                        tms_d   = 1'b0;
                    end else begin
                        state_d = SHIFT;
                        bit_d   = 7'd0;
                        tms_d   = (len_q == 7'd1);
                        tdi_d   = data_q[0];
                    end
                end
            end
            SHIFT: begin
                if (bit_done) begin
                    if (last_bit) begin
                        state_d = POST;
                        bit_d   = 7'd0;
                        tms_d   = 1'b1;
                        tdi_d   = 1'b0;
                    end else begin
                        bit_d = bit_nxt;
                        // TMS rises on the final shift bit to leave via Exit1.
                        tms_d = (bit_nxt == len_q - 7'd1);
                        tdi_d = data_q[bit_nxt[5:0]];
                    end
                end
            end
            POST: begin
                if (bit_done) begin
                    if (last_bit) begin
                        state_d = RESP;
                    end else begin
                        bit_d = bit_nxt;
                    end
                    tms_d = 1'b0;
                end
            end
            RESP: begin
                if (bus.i_resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q <= IDLE;
            bit_q   <= 7'd0;
            div_q   <= '0;
            tck_q   <= 1'b0;
            tms_q   <= 1'b0;
            tdi_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            tms_q   <= tms_d;
            tdi_q   <= tdi_d;
            // TCK runs only while a scan is on the wire; each half lasts CLK_DIV cycles.
            if (state_q == PRE || state_q == SHIFT || state_q == POST) begin
                if (div_q == DIV_LAST) begin
                    div_q <= '0;
                    tck_q <= ~tck_q;
                end else begin
                    div_q <= div_q + DIV_W'(1);
                end
            end else begin
                div_q <= '0;
                tck_q <= 1'b0;
            end
        end
    end

    // Request payload and capture register carry no reset; the response data
    // output is gated so nothing leaks out while idle or in reset.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            ir_q   <= bus.i_req_ir;
            len_q  <= len_clip;
            data_q <= bus.i_req_data;
            cap_q  <= '0;
        end else if (sample) begin
            // Writing shift k into bit k leaves the result right-aligned and
            // zero above len without a final alignment step.
            cap_q[bit_q[5:0]] <= bus.i_tdo;
        end
    end

    assign bus.o_req_ready  = i_nrst && (state_q == IDLE);
    assign bus.o_resp_valid = (state_q == RESP);
    assign bus.o_resp_data  = (state_q == RESP) ? cap_q : 64'd0;
    assign bus.o_tck        = tck_q;
    assign bus.o_tms        = tms_q;
    assign bus.o_tdi        = tdi_q;

endmodule
